// File: rtl/custom_leds_pwm_if.sv
// Avalon-MM slave bundle for the LED/button peripheral.
// The bridge drives the request fields and samples readdata.
interface custom_leds_pwm_if;
    logic [3:0]  avs_s0_address;
    logic        avs_s0_read;
    logic        avs_s0_write;
    logic [31:0] avs_s0_writedata;
    logic [31:0] avs_s0_readdata;

    modport master (
        output avs_s0_address,
        output avs_s0_read,
        output avs_s0_write,
        output avs_s0_writedata,
        input  avs_s0_readdata
    );

    modport slave (
        input  avs_s0_address,
        input  avs_s0_read,
        input  avs_s0_write,
        input  avs_s0_writedata,
        output avs_s0_readdata
    );
endinterface

// File: rtl/custom_leds_pwm.sv
// LED/button peripheral: per-LED PWM with period-aligned duty reload,
// debounced buttons, sticky press capture and a level interrupt.
module custom_leds_pwm #(
    parameter int NUM_LEDS        = 8,
    parameter int NUM_BTNS        = 4,
    parameter int PWM_BITS        = 8,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                clk,
    input  logic                reset,
    custom_leds_pwm_if.slave    avs,
    input  logic [NUM_BTNS-1:0] button_in_port,
    output logic [NUM_LEDS-1:0] leds,
    output logic                irq
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PWM_BITS-1:0] CNT_LAST =
        PWM_BITS'((1 << PWM_BITS) - 2);

    logic                pwm_en_q, pwm_en_d;
    logic                irq_en_q, irq_en_d;
    logic [NUM_LEDS-1:0] led_q, led_d;
    logic [15:0]         prescale_q, prescale_d;
    logic [PWM_BITS-1:0] duty_q [NUM_LEDS];
    logic [PWM_BITS-1:0] duty_d [NUM_LEDS];
    logic [PWM_BITS-1:0] act_q  [NUM_LEDS];
    logic [PWM_BITS-1:0] act_d  [NUM_LEDS];
    logic [NUM_BTNS-1:0] sync1_q, sync1_d;
    logic [NUM_BTNS-1:0] sync2_q, sync2_d;
    logic [NUM_BTNS-1:0] btn_q, btn_d;
    logic [NUM_BTNS-1:0] cap_q, cap_d;
    logic [CW-1:0]       db_q [NUM_BTNS];
    logic [CW-1:0]       db_d [NUM_BTNS];
    logic [15:0]         psc_q, psc_d;
    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    logic [NUM_LEDS-1:0] leds_q, leds_d;
    logic                irq_q, irq_d;
    logic [31:0]         rdata_q, rdata_d;

    logic [NUM_LEDS-1:0] pwm_on;
    logic [NUM_BTNS-1:0] w1c;
    logic [31:0]         rmux;
    logic                tick;
    logic                wr;
    logic [3:0]          addr;

    assign wr   = avs.avs_s0_write;
    assign addr = avs.avs_s0_address;

    always_comb begin
        pwm_en_d   = pwm_en_q;
        irq_en_d   = irq_en_q;
        led_d      = led_q;
        prescale_d = prescale_q;
        duty_d     = duty_q;
        act_d      = act_q;
        db_d       = db_q;
        btn_d      = btn_q;
        sync1_d    = button_in_port;
        sync2_d    = sync1_q;
        w1c        = '0;
        cnt_d      = cnt_q;
        pwm_on     = '0;
        rmux       = '0;
        rdata_d    = rdata_q;

        if (wr && addr == 4'd0) begin
            pwm_en_d = avs.avs_s0_writedata[0];
            irq_en_d = avs.avs_s0_writedata[1];
        end
        if (wr && addr == 4'd1)
            led_d = avs.avs_s0_writedata[NUM_LEDS-1:0];
        if (wr && addr == 4'd3)
            w1c = avs.avs_s0_writedata[NUM_BTNS-1:0];
        if (wr && addr == 4'd4)
            prescale_d = avs.avs_s0_writedata[15:0];
        for (int i = 0; i < NUM_LEDS; i++)
            if (wr && addr == 4'(8 + i))
                duty_d[i] = avs.avs_s0_writedata[PWM_BITS-1:0];

        // Counter only runs while the synchronized level disagrees with BTN.
        for (int i = 0; i < NUM_BTNS; i++) begin
            if (sync2_q[i] == btn_q[i]) begin
                db_d[i] = '0;
            end else if (db_q[i] == DB_LAST) begin
                btn_d[i] = sync2_q[i];
                db_d[i]  = '0;
            end else begin
                db_d[i] = db_q[i] + CW'(1);
            end
        end
        cap_d = (cap_q & ~w1c) | (btn_d & ~btn_q);
        irq_d = irq_en_q & (|cap_q);

        tick  = (psc_q == prescale_q);
        psc_d = tick ? 16'd0 : psc_q + 16'd1;
        if (wr && addr == 4'd4)
            psc_d = 16'd0;
        // Duty reloads only at the period boundary so a period is never cut.
        if (tick) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                act_d = duty_q;
            end else begin
                cnt_d = cnt_q + PWM_BITS'(1);
            end
        end
        for (int i = 0; i < NUM_LEDS; i++)
            pwm_on[i] = (cnt_q < act_q[i]);
        leds_d = led_q & (pwm_en_q ? pwm_on : '1);

        case (addr)
            4'd0: rmux[1:0] = {irq_en_q, pwm_en_q};
            4'd1: rmux[NUM_LEDS-1:0] = led_q;
            4'd2: rmux[NUM_BTNS-1:0] = btn_q;
            4'd3: rmux[NUM_BTNS-1:0] = cap_q;
            4'd4: rmux[15:0] = prescale_q;
            default: begin
                for (int i = 0; i < NUM_LEDS; i++)
                    if (addr == 4'(8 + i))
                        rmux[PWM_BITS-1:0] = duty_q[i];
            end
        endcase
        if (avs.avs_s0_read)
            rdata_d = rmux;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_en_q   <= 1'b0;
            irq_en_q   <= 1'b0;
            led_q      <= '0;
            prescale_q <= '0;
            for (int i = 0; i < NUM_LEDS; i++) begin
                duty_q[i] <= '0;
                act_q[i]  <= '0;
            end
            for (int i = 0; i < NUM_BTNS; i++)
                db_q[i] <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
            btn_q   <= '0;
            cap_q   <= '0;
            psc_q   <= '0;
            cnt_q   <= '0;
            leds_q  <= '0;
            irq_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            pwm_en_q   <= pwm_en_d;
            irq_en_q   <= irq_en_d;
            led_q      <= led_d;
            prescale_q <= prescale_d;
            duty_q     <= duty_d;
            act_q      <= act_d;
            db_q       <= db_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            btn_q      <= btn_d;
            cap_q      <= cap_d;
            psc_q      <= psc_d;
            cnt_q      <= cnt_d;
            leds_q     <= leds_d;
            irq_q      <= irq_d;
            rdata_q    <= rdata_d;
        end
    end

    assign leds                = leds_q;
    assign irq                 = irq_q;
    assign avs.avs_s0_readdata = rdata_q;
endmodule
